// File: rtl/detect_pkg.sv
// Shared types and the 7-segment lookup for the detector event counter.
package detect_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    ARMED    = 2'd1,
    QUAL     = 2'd2,
    HIGH     = 2'd3
  } det_state_t;

  typedef logic [3:0] bcd_digit_t;

  // Segment patterns, bit 0 = a .. bit 6 = g, active-high.
  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to 7-segment pattern; non-decimal codes blank the display.
module seg7_decode
  import detect_pkg::*;
(
  input  bcd_digit_t  i_digit,
  output logic [6:0]  o_seg
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    o_seg = 7'h00;
    if (i_digit <= 4'd9) begin
      o_seg = SEG_LUT[i_digit];
    end
  end

endmodule

// File: rtl/detect_event_counter.sv
// Qualified rising-event counter (2-digit BCD) with 7-segment output.
// Define DETECT_SAT_EN to saturate at 99 instead of wrapping to 00.
module detect_event_counter
  import detect_pkg::*;
#(
  parameter int unsigned MIN_HIGH = 1
)(
  input  logic       clk_2,
  input  logic       reset,
  input  logic       det_in,
  input  logic       clear,
  input  logic       hold,
  input  logic       digit_sel,
  output logic [7:0] count_bcd,
  output logic       event_pulse,
  output logic       overflow,
  output logic [7:0] seg
);

  localparam logic [3:0] MIN_HIGH_Q = 4'(MIN_HIGH);

  det_state_t  r_state, w_next_state;
  logic [3:0]  r_qcnt, w_next_qcnt;
  logic        w_inc;

  bcd_digit_t  r_tens, r_units;
  bcd_digit_t  w_tens_next, w_units_next;
  logic        w_wrap;
  logic        r_pulse, r_ovf;

  bcd_digit_t  w_sel_digit;
  logic [6:0]  w_seg7;

  always_comb begin
    w_next_state = r_state;
    w_next_qcnt  = r_qcnt;
    w_inc        = 1'b0;
    unique case (r_state)
      WAIT_LOW: begin
        if (!det_in) w_next_state = ARMED;
      end
      ARMED: begin
        if (det_in) begin
          if (MIN_HIGH == 1) begin
            w_next_state = HIGH;
            w_inc        = 1'b1;
          end else begin
            w_next_state = QUAL;
            w_next_qcnt  = 4'd1;
          end
        end
      end
      QUAL: begin
        if (!det_in) begin
          w_next_state = ARMED;
          w_next_qcnt  = 4'd0;
        end else if (r_qcnt + 4'd1 == MIN_HIGH_Q) begin
          w_next_state = HIGH;
          w_next_qcnt  = 4'd0;
          w_inc        = 1'b1;
        end else begin
          w_next_qcnt  = r_qcnt + 4'd1;
        end
      end
      HIGH: begin
        if (!det_in) w_next_state = ARMED;
      end
      default: w_next_state = WAIT_LOW;
    endcase
  end

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state <= WAIT_LOW;
      r_qcnt  <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_qcnt  <= w_next_qcnt;
    end
  end

  always_comb begin
    w_wrap       = (r_tens == 4'd9) && (r_units == 4'd9);
    w_units_next = r_units + 4'd1;
    w_tens_next  = r_tens;
    if (r_units == 4'd9) begin
      w_units_next = 4'd0;
      w_tens_next  = (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
    end
  end

  // clear beats hold beats inc; the FSM above runs regardless.
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      r_tens  <= 4'd0;
      r_units <= 4'd0;
      r_pulse <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_tens  <= 4'd0;
      r_units <= 4'd0;
      r_pulse <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (hold || !w_inc) begin
      r_pulse <= 1'b0;
    end else begin
`ifdef DETECT_SAT_EN
      if (w_wrap) begin
        r_ovf   <= 1'b1;
        r_pulse <= 1'b0;
      end else begin
        r_tens  <= w_tens_next;
        r_units <= w_units_next;
        r_pulse <= 1'b1;
      end
`else
      r_tens  <= w_tens_next;
      r_units <= w_units_next;
      r_pulse <= 1'b1;
      if (w_wrap) r_ovf <= 1'b1;
`endif
    end
  end

  assign w_sel_digit = digit_sel ? r_tens : r_units;

  seg7_decode u_seg7_decode (
    .i_digit (w_sel_digit),
    .o_seg   (w_seg7)
  );

  assign count_bcd   = {r_tens, r_units};
  assign event_pulse = r_pulse;
  assign overflow    = r_ovf;
  assign seg         = {r_ovf, w_seg7};

endmodule

// File: doc/detect_event_counter.md
Name: detect_event_counter

Overview:
- Downstream stage of the 3-consecutive-ones sequence detector.
- Consumes the detector's level output (high while in final state D) and counts qualified rising events as a 2-digit BCD value, 00..99.
- Drives one 7-segment display (units or tens digit, selectable) and exposes the raw BCD count for LEDs.
- Includes a glitch qualifier, so a detector level must persist before it counts.

Parameters:
- MIN_HIGH, 1, consecutive clk_2 edges det_in must be sampled high before an event counts; legal 1..15.

Ports:
- clk_2  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0); release synchronous to clk_2.
- det_in  input  1  detector output level, same clock domain, no synchroniser.
- clear  input  1  synchronous clear of count and overflow flag.
- hold  input  1  freezes the count; edge tracking continues.
- digit_sel  input  1  display select: 0 = units, 1 = tens.
- count_bcd  output  8  {tens[3:0], units[3:0]}.
- event_pulse  output  1  one-cycle strobe, registered, one cycle after each counted event.
- overflow  output  1  sticky flag: count passed 99.
- seg  output  8  seg[0]=a .. seg[6]=g, seg[7]=dp, active-high.

Behaviour:
- Reset (reset=0, async):
  - FSM = WAIT_LOW, qualifier counter = 0, count_bcd = 8'h00.
  - overflow = 0, event_pulse = 0.
  - seg shows digit 0 with dp off (8'h3F).
- FSM states: WAIT_LOW, ARMED, QUAL, HIGH.
  - WAIT_LOW: det_in=0 -> ARMED. A level already high at reset release is never counted.
  - ARMED, det_in=1:
    - MIN_HIGH=1 -> HIGH, inc asserted.
    - Otherwise -> QUAL, qcnt=1.
  - QUAL:
    - det_in=0 -> ARMED, qcnt=0.
    - det_in=1 and qcnt+1==MIN_HIGH -> HIGH, inc asserted.
    - Otherwise qcnt++.
  - HIGH: det_in=0 -> ARMED. Staying high never re-counts.
- inc is combinational from the FSM. Count updates on the same edge the FSM enters HIGH. event_pulse goes high for the following cycle only if the increment was applied.
- BCD arithmetic:
  - units 9 -> 0 with carry into tens.
  - 99 + 1 -> 00 and overflow set (wrap mode).
  - Digits never hold values above 9.
- Priority per edge: clear > hold > inc.
  - clear: count = 00, overflow = 0, no event_pulse. FSM is unaffected.
  - hold=1: inc is discarded (event lost, no event_pulse). FSM still advances to HIGH, so releasing hold while det_in is high does not count.
- seg[6:0] decodes the selected digit:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - seg[7] = overflow.
  - seg is purely combinational from registered state and digit_sel.
- All outputs are glitch-free registered values, except seg (combinational decode of registers).
- Reset asserted mid-qualification or mid-HIGH returns everything to reset values immediately.

Optional Feature:
- Macro: DETECT_SAT_EN.
- Defined: count saturates at 99. A further inc leaves the count at 99, sets overflow, and produces no event_pulse.
- Undefined: wrap to 00 as above, with event_pulse asserted.

Decomposition:
- Package detect_pkg contains:
  - enum logic [1:0] det_state_t {WAIT_LOW, ARMED, QUAL, HIGH}.
  - typedef logic [3:0] bcd_digit_t.
  - localparam logic [6:0] SEG_LUT[0:9].
- One sub-module, seg7_decode: bcd_digit_t in, 7-bit segments out. Input > 9 yields 7'h00.

Test Plan:
- Reset, det_in=0, then one det_in pulse of 1 cycle (MIN_HIGH=1) -> count_bcd=01, event_pulse high exactly the next cycle, seg=06.
- det_in held high 20 cycles -> count increments once only; drop then re-raise -> count=02.
- MIN_HIGH=3: det_in high 2 cycles, low, high 3 cycles -> only the second burst counts, count=01 on the 3rd high edge.
- 100 qualified events -> count 99 then 00, overflow=1, seg[7]=1. With DETECT_SAT_EN: count stays 99, no 100th event_pulse.
- clear and qualifying event on the same edge -> count=00, overflow=0, no event_pulse. hold=1 during an event -> count unchanged, no event_pulse.
- det_in high at reset release -> no count until det_in falls and rises again. Reset pulsed during QUAL -> count 00, outputs at reset values asynchronously.
